// File: rtl/wide_add_pkg.sv
// Shared types and constants for the sequential wide adder.
package wide_add_pkg;

    localparam int unsigned SLICE_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Slice counter width; at least one bit so the counter always exists.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/carry_select_adder16.sv
// 16-bit carry-select adder: low byte ripples, high byte precomputed for both carries.
module carry_select_adder16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        cin,
    output logic        cout,
    output logic [15:0] sum
);

    logic [8:0] lo;
    logic [8:0] hi0;
    logic [8:0] hi1;

    // Both high-byte candidates, selected by the low-byte carry.
    always_comb begin
        lo   = {1'b0, a[7:0]} + {1'b0, b[7:0]} + {8'b0, cin};
        hi0  = {1'b0, a[15:8]} + {1'b0, b[15:8]};
        hi1  = hi0 + 9'd1;
        sum  = {(lo[8] ? hi1[7:0] : hi0[7:0]), lo[7:0]};
        cout = lo[8] ? hi1[8] : hi0[8];
    end

endmodule

// File: rtl/wide_add_seq16.sv
// Multi-cycle wide adder: one 16-bit slice per cycle through carry_select_adder16.
// Optional subtract support is enabled by defining WIDE_ADD_SUB_EN.
module wide_add_seq16
    import wide_add_pkg::*;
#(
    parameter int unsigned NWORDS = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [16*NWORDS-1:0]      in_a,
    input  logic [16*NWORDS-1:0]      in_b,
    input  logic                      in_cin,
`ifdef WIDE_ADD_SUB_EN
    input  logic                      in_sub,
`endif
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [16*NWORDS-1:0]      out_sum,
    output logic                      out_cout,
    output logic                      out_ovf
);

    localparam int unsigned W     = SLICE_W * NWORDS;
    localparam int unsigned CNT_W = cnt_width(NWORDS);

    state_e state_q, state_d;

    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;
    logic [W-1:0]     sum_q, sum_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             cin_q, cin_d;
    logic             valid_q, valid_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic               accept_c;
    logic               last_c;
    logic [SLICE_W-1:0] add_sum_c;
    logic               add_cout_c;
    logic               b_in_inv_c;

    carry_select_adder16 u_add (
        .a    (a_q[SLICE_W-1:0]),
        .b    (b_q[SLICE_W-1:0]),
        .cin  (cin_q),
        .cout (add_cout_c),
        .sum  (add_sum_c)
    );

    assign last_c = (cnt_q == CNT_W'(NWORDS - 1));

`ifdef WIDE_ADD_SUB_EN
    assign b_in_inv_c = in_sub;
`else
    assign b_in_inv_c = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept_c)  state_d = RUN;
            RUN:     if (last_c)    state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs decoded from state; held low while in reset.
    always_comb begin
        in_ready = (state_q == IDLE) && !rst;
        accept_c = in_ready && in_valid;
    end

    // Datapath next values: load on accept, shift one slice per RUN cycle.
    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        cin_d   = cin_q;
        valid_d = valid_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        if (accept_c) begin
            a_d   = in_a;
            b_d   = b_in_inv_c ? ~in_b : in_b;
            cin_d = b_in_inv_c ? 1'b1 : in_cin;
            cnt_d = '0;
        end else if (state_q == RUN) begin
            a_d   = {{SLICE_W{1'b0}}, a_q[W-1:SLICE_W]};
            b_d   = {{SLICE_W{1'b0}}, b_q[W-1:SLICE_W]};
            sum_d = {add_sum_c, sum_q[W-1:SLICE_W]};
            cin_d = add_cout_c;
            cnt_d = cnt_q + CNT_W'(1);
            if (last_c) begin
                valid_d = 1'b1;
                cout_d  = add_cout_c;
                // Top-slice sign bits: operands agree but the sum differs.
                ovf_d   = (a_q[SLICE_W-1] == b_q[SLICE_W-1]) &&
                          (add_sum_c[SLICE_W-1] != a_q[SLICE_W-1]);
            end
        end else if ((state_q == DONE) && out_ready) begin
            valid_d = 1'b0;
        end
    end

    // Datapath registers with synchronous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            cin_q   <= 1'b0;
            valid_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            cin_q   <= cin_d;
            valid_q <= valid_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign out_valid = valid_q;
    assign out_sum   = sum_q;
    assign out_cout  = cout_q;
    assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_wide_add_seq16.sv
// Scoreboard bench for wide_add_seq16 with NWORDS = 4.
module tb_wide_add_seq16;

    localparam int unsigned NW = 4;
    localparam int unsigned W  = 16 * NW;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_cin;
`ifdef WIDE_ADD_SUB_EN
    logic         in_sub;
`endif
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] out_sum;
    logic         out_cout;
    logic         out_ovf;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    wide_add_seq16 #(.NWORDS(NW)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
`ifdef WIDE_ADD_SUB_EN
        .in_sub    (in_sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Monitor: compare each result at the cycle it is consumed.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL sb_unexpected: got result %h, expected none", out_sum);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sb_sum", out_sum, e.sum);
                check("sb_cout", W'(out_cout), W'(e.cout));
                check("sb_ovf", W'(out_ovf), W'(e.ovf));
            end
        end
    end

    // Present a request, wait for acceptance, and record its expected result.
    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin,
                        input logic sub, input logic [W-1:0] es, input logic ec,
                        input logic eo);
        int k;
        exp_t e;
        k = 0;
        in_a     = a;
        in_b     = b;
        in_cin   = cin;
`ifdef WIDE_ADD_SUB_EN
        in_sub   = sub;
`endif
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!in_ready) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: in_ready 0, expected 1");
        end else begin
            e.sum  = es;
            e.cout = ec;
            e.ovf  = eo;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (sub) begin end
    endtask

    // Edges from acceptance until out_valid is seen, bounded.
    task automatic wait_valid(output int n);
        n = 0;
        while (n < 50) begin
            @(posedge clk);
            #1;
            n++;
            if (out_valid) break;
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int n;
        logic [W-1:0] held;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_cin    = 1'b0;
`ifdef WIDE_ADD_SUB_EN
        in_sub    = 1'b0;
`endif
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", W'(in_ready), W'(0));
        check("rst_out_valid", W'(out_valid), W'(0));
        check("rst_out_sum", out_sum, '0);
        check("rst_out_cout", W'(out_cout), W'(0));
        check("rst_out_ovf", W'(out_ovf), W'(0));
        rst = 1'b0;
        #1;
        check("idle_in_ready", W'(in_ready), W'(1));

        // Full carry ripple, with latency measurement.
        send(64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0);
        wait_valid(n);
        check("latency", W'(n), W'(NW));

        // Signed overflow.
        send(64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1);
        // Carry-in crossing into slice 1.
        send(64'h0000_0000_0000_FFFF, 64'h0, 1'b1, 1'b0, 64'h0000_0000_0001_0000, 1'b0, 1'b0);
        wait_valid(n);
        @(posedge clk);
        #1;

        // Backpressure: hold DONE for 3 cycles.
        out_ready = 1'b0;
        send(64'h1234_5678_9ABC_DEF0, 64'h1111_1111_1111_1111, 1'b0, 1'b0,
             64'h2345_6789_ABCD_F001, 1'b0, 1'b0);
        wait_valid(n);
        held = 64'h2345_6789_ABCD_F001;
        for (int i = 0; i < 3; i++) begin
            check("bp_valid", W'(out_valid), W'(1));
            check("bp_sum_stable", out_sum, held);
            check("bp_in_ready", W'(in_ready), W'(0));
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_in_ready", W'(in_ready), W'(1));
        // Back-to-back request accepted right away.
        send(64'h2, 64'h3, 1'b0, 1'b0, 64'h5, 1'b0, 1'b0);
        wait_valid(n);
        check("b2b_latency", W'(n), W'(NW));

        // Mid-operation reset during slice 2.
        @(posedge clk);
        #1;
        send(64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        void'(sb.pop_back());
        @(posedge clk);
        #1;
        check("mid_rst_valid", W'(out_valid), W'(0));
        check("mid_rst_sum", out_sum, '0);
        check("mid_rst_in_ready", W'(in_ready), W'(0));
        rst = 1'b0;
        #1;
        check("post_rst_in_ready", W'(in_ready), W'(1));
        send(64'h3, 64'h4, 1'b0, 1'b0, 64'h7, 1'b0, 1'b0);
        wait_valid(n);
        check("post_rst_latency", W'(n), W'(NW));

`ifdef WIDE_ADD_SUB_EN
        @(posedge clk);
        #1;
        send(64'h5, 64'h7, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
        wait_valid(n);
`endif

        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        repeat (2) @(posedge clk);
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL sb_drain: %0d results outstanding, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/wide_add_seq16.md
# wide_add_seq16

Multi-cycle wide adder that sequences N×16-bit operands through one instance of the 16-bit carry-select adder, one 16-bit slice per cycle. The carry-out of each slice is registered and fed back as the next slice's carry-in. Operands arrive on a valid/ready input port and the wide sum leaves on a valid/ready output port. It is the operand feeder and result collector wrapped around the 16-bit adder datapath, for widths the combinational adder cannot cover in one cycle.

## Interface
- NWORDS, 4, number of 16-bit slices; operand width W = 16*NWORDS; legal range 2..16
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operand request valid
- in_ready  output  1  block can accept an operand request
- in_a  input  W  operand A
- in_b  input  W  operand B
- in_cin  input  1  carry into slice 0 (add only)
- in_sub  input  1  1 = A − B; port exists only when WIDE_ADD_SUB_EN is defined
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- out_sum  output  W  wide sum / difference
- out_cout  output  1  carry out of the top slice (for subtract: 1 = no borrow)
- out_ovf  output  1  two's-complement signed overflow

## Operation
- FSM states: IDLE, RUN, DONE. Slice counter width is clog2(NWORDS).
- IDLE:
  - in_ready = 1 when rst = 0.
  - On in_valid & in_ready: load the A and B shift registers and the carry register (cin_q = in_cin), clear the counter, go to RUN.
- RUN:
  - The adder sees the low slice of each shift register and cin_q.
  - Each cycle: capture the adder sum into the top of the sum shift register and shift everything right 16 bits. Set cin_q = adder cout and increment the counter.
  - Also capture the MSB of the A and B slices on every cycle; only the last slice's capture is used for out_ovf.
  - After slice NWORDS−1, go to DONE.
- DONE:
  - out_valid = 1. out_sum, out_cout and out_ovf stay stable.
  - On out_ready, go to IDLE.
- Overflow rule: out_ovf = (a_msb == b_eff_msb) & (sum_msb != a_msb), where b_eff is B as fed to the adder.
- in_ready is 0 in RUN and DONE. Requests arriving then are held off, not dropped.
- Reset at any point, including mid-RUN, aborts the operation:
  - next state is IDLE;
  - out_valid, out_sum, out_cout and out_ovf go to 0;
  - counter and cin_q are cleared;
  - in_ready is 0 while rst is high.
- Reset values of all outputs: in_ready 0 (while rst is high), out_valid 0, out_sum 0, out_cout 0, out_ovf 0.

## Timing
- Accept edge E0. RUN occupies edges E1..E_NWORDS.
- out_valid rises after edge E_NWORDS: the accept-to-valid latency is NWORDS edges.
- The result handshake completes at the edge where out_valid & out_ready.
- in_ready is 1 in the following cycle.
- Minimum issue interval is NWORDS+2 cycles.
- out_ready held high in DONE costs exactly one DONE cycle.
- Critical path is one adder16 traversal plus the register setup. There is no combinational path from inputs to outputs.

## Configuration
- WIDE_ADD_SUB_EN defined:
  - in_sub port is present.
  - When in_sub = 1 at accept: B is stored inverted, cin_q loads 1, and in_cin is ignored.
  - out_cout = NOT borrow.
- WIDE_ADD_SUB_EN undefined:
  - in_sub port is absent. The block is add-only and cin_q loads in_cin.

## Structure
- Package wide_add_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - SLICE_W = 16;
  - a helper function for counter width.
- One sub-module instance: carry_select_adder16. It is used unmodified (ports a, b, cin, cout, sum).
- All sequencing, shift registers and handshake logic live in wide_add_seq16.

## Test plan
All scenarios use NWORDS = 4.

- Full carry ripple: A = 0xFFFF_FFFF_FFFF_FFFF, B = 1, cin = 0 -> out_sum = 0, out_cout = 1, out_ovf = 0. out_valid rises exactly 4 edges after accept.
- Signed overflow: A = 0x7FFF_FFFF_FFFF_FFFF, B = 1 -> out_sum = 0x8000_0000_0000_0000, out_cout = 0, out_ovf = 1.
- Cross-slice cin: A = 0x0000_0000_0000_FFFF, B = 0, cin = 1 -> out_sum = 0x0000_0000_0001_0000, out_cout = 0.
- Backpressure:
  - Hold out_ready = 0 for 3 cycles in DONE -> out_sum stays stable and in_ready = 0.
  - Raise out_ready -> in_ready = 1 the next cycle.
  - A back-to-back second request is accepted then.
- Mid-operation reset: assert rst for 1 cycle at RUN slice 2 -> next cycle out_valid = 0 and out_sum = 0; in_ready = 1 once rst is low. A following A = 3, B = 4 gives 7.
- Subtract (macro on): A = 5, B = 7, in_sub = 1 -> out_sum = 0xFFFF_FFFF_FFFF_FFFE, out_cout = 0, out_ovf = 0. With the macro off, an elaboration check confirms the in_sub port is absent.
